// File: rtl/rv_inst_pkg.sv
// RV32I encoding constants, operation enum and immediate range helper
// shared by the encoder top and its word-encode sub-module.
package rv_inst;

   typedef enum logic [4:0] {
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI,
      OP_SRAI, OP_LUI, OP_AUIPC, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_AND,
      OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_JAL, OP_JALR, OP_BEQ,
      OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_LI
   } rv_32i_op_t;

   typedef enum logic [2:0] {
      FMT_I, FMT_SH, FMT_R, FMT_B, FMT_U, FMT_J, FMT_BAD
   } rv_fmt_t;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // A signed field fits when every bit above its sign bit equals the sign bit.
   function automatic logic imm_fits(input rv_fmt_t fmt, input logic [31:0] imm);
      case (fmt)
         FMT_I:   return imm[31:11] == {21{imm[31]}};
         FMT_SH:  return imm[31:5] == 27'd0;
         FMT_R:   return 1'b1;
         FMT_B:   return (imm[0] == 1'b0) && (imm[31:12] == {20{imm[31]}});
         FMT_U:   return imm[11:0] == 12'd0;
         FMT_J:   return (imm[0] == 1'b0) && (imm[31:20] == {12{imm[31]}});
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv_32i_encode_word.sv
// Combinational RV32I word encoder. RV_32I_ENCODER_CHECK_EN enables immediate
// range checking (out-of-range -> NOP + error); otherwise immediates truncate.
module rv_32i_encode_word
   import rv_inst::*;
(
   input  logic [4:0]  op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        error
);

   rv_32i_op_t  op_e;
   rv_fmt_t     fmt;
   logic [6:0]  opc;
   logic [6:0]  f7;
   logic [2:0]  f3;
   logic [31:0] raw;

   assign op_e = rv_32i_op_t'(op);

   always_comb begin
      fmt = FMT_BAD;
      opc = OPC_OP_IMM;
      f3  = F3_ADD;
      f7  = F7_BASE;
      case (op_e)
         OP_ADDI:  begin fmt = FMT_I;  f3 = F3_ADD;  end
         OP_SLTI:  begin fmt = FMT_I;  f3 = F3_SLT;  end
         OP_SLTIU: begin fmt = FMT_I;  f3 = F3_SLTU; end
         OP_ANDI:  begin fmt = FMT_I;  f3 = F3_AND;  end
         OP_ORI:   begin fmt = FMT_I;  f3 = F3_OR;   end
         OP_XORI:  begin fmt = FMT_I;  f3 = F3_XOR;  end
         OP_SLLI:  begin fmt = FMT_SH; f3 = F3_SLL;  end
         OP_SRLI:  begin fmt = FMT_SH; f3 = F3_SR;   end
         OP_SRAI:  begin fmt = FMT_SH; f3 = F3_SR; f7 = F7_ALT; end
         OP_LUI:   begin fmt = FMT_U;  opc = OPC_LUI;   end
         OP_AUIPC: begin fmt = FMT_U;  opc = OPC_AUIPC; end
         OP_ADD:   begin fmt = FMT_R;  opc = OPC_OP; f3 = F3_ADD;  end
         OP_SUB:   begin fmt = FMT_R;  opc = OPC_OP; f3 = F3_ADD; f7 = F7_ALT; end
         OP_SLT:   begin fmt = FMT_R;  opc = OPC_OP; f3 = F3_SLT;  end
         OP_SLTU:  begin fmt = FMT_R;  opc = OPC_OP; f3 = F3_SLTU; end
         OP_AND:   begin fmt = FMT_R;  opc = OPC_OP; f3 = F3_AND;  end
         OP_OR:    begin fmt = FMT_R;  opc = OPC_OP; f3 = F3_OR;   end
         OP_XOR:   begin fmt = FMT_R;  opc = OPC_OP; f3 = F3_XOR;  end
         OP_SLL:   begin fmt = FMT_R;  opc = OPC_OP; f3 = F3_SLL;  end
         OP_SRL:   begin fmt = FMT_R;  opc = OPC_OP; f3 = F3_SR;   end
         OP_SRA:   begin fmt = FMT_R;  opc = OPC_OP; f3 = F3_SR; f7 = F7_ALT; end
         OP_JAL:   begin fmt = FMT_J;  opc = OPC_JAL;  end
         OP_JALR:  begin fmt = FMT_I;  opc = OPC_JALR; end
         OP_BEQ:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BEQ;  end
         OP_BNE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BNE;  end
         OP_BLT:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLT;  end
         OP_BGE:   begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGE;  end
         OP_BLTU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BLTU; end
         OP_BGEU:  begin fmt = FMT_B;  opc = OPC_BRANCH; f3 = F3_BGEU; end
         default:  fmt = FMT_BAD;
      endcase
   end

   always_comb begin
      raw = NOP_INST;
      case (fmt)
         FMT_I:   raw = {imm[11:0], rs1, f3, rd, opc};
         FMT_SH:  raw = {f7, imm[4:0], rs1, f3, rd, opc};
         FMT_R:   raw = {f7, rs2, rs1, f3, rd, opc};
         FMT_B:   raw = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
         FMT_U:   raw = {imm[31:12], rd, opc};
         FMT_J:   raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
         default: raw = NOP_INST;
      endcase
   end

`ifdef RV_32I_ENCODER_CHECK_EN
   assign error = !imm_fits(fmt, imm);
   assign word  = error ? NOP_INST : raw;
`else
   assign error = 1'b0;
   assign word  = raw;
`endif

endmodule

// File: rtl/rv_32i_encoder.sv
// Streaming RV32I encoder: handshake FSM, output register, LI -> LUI+ADDI split
// and word counter. Range checks follow RV_32I_ENCODER_CHECK_EN in the word encoder.
module rv_32i_encoder
   import rv_inst::*;
#(
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4:0]             in_op,
   input  logic [4:0]             in_rd,
   input  logic [4:0]             in_rs1,
   input  logic [4:0]             in_rs2,
   input  logic [31:0]            in_imm,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [31:0]            out_inst,
   output logic                   out_last,
   output logic                   out_error,
   output logic [COUNT_WIDTH-1:0] out_count
);

   typedef enum logic [1:0] {IDLE, SINGLE, LI_HI, LI_LO} state_t;

   state_t                 state_reg;
   logic [31:0]            inst_reg;
   logic [31:0]            pending_reg;
   logic                   last_reg;
   logic                   error_reg;
   logic [COUNT_WIDTH-1:0] count_reg;

   logic        accept;
   logic        fire;
   logic        is_li;
   logic        li_small;
   logic        li_two;
   logic [31:0] li_hi_imm;

   logic [4:0]  enc_op   [2];
   logic [4:0]  enc_rd   [2];
   logic [4:0]  enc_rs1  [2];
   logic [4:0]  enc_rs2  [2];
   logic [31:0] enc_imm  [2];
   logic [31:0] enc_word [2];
   logic        enc_err  [2];

   assign out_valid = (state_reg != IDLE);
   assign in_ready  = (state_reg == IDLE) |
                      (out_ready & ((state_reg == SINGLE) | (state_reg == LI_LO)));
   assign accept    = in_valid & in_ready;
   assign fire      = out_valid & out_ready;

   // Rounding the upper part by 0x800 compensates for ADDI sign-extending lo.
   assign is_li     = (in_op == OP_LI);
   assign li_small  = imm_fits(FMT_I, in_imm);
   assign li_hi_imm = (in_imm + 32'h0000_0800) & 32'hFFFF_F000;
   assign li_two    = is_li & !li_small & (in_imm[11:0] != 12'd0);

   // Slot 0 is the first word of the descriptor; slot 1 is the trailing LI ADDI.
   assign enc_op[0]  = is_li ? (li_small ? OP_ADDI : OP_LUI) : in_op;
   assign enc_rd[0]  = in_rd;
   assign enc_rs1[0] = is_li ? 5'd0 : in_rs1;
   assign enc_rs2[0] = in_rs2;
   assign enc_imm[0] = (is_li & !li_small) ? li_hi_imm : in_imm;

   assign enc_op[1]  = OP_ADDI;
   assign enc_rd[1]  = in_rd;
   assign enc_rs1[1] = in_rd;
   assign enc_rs2[1] = 5'd0;
   assign enc_imm[1] = {{20{in_imm[11]}}, in_imm[11:0]};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_enc
         rv_32i_encode_word u_enc (
            .op    (enc_op[gi]),
            .rd    (enc_rd[gi]),
            .rs1   (enc_rs1[gi]),
            .rs2   (enc_rs2[gi]),
            .imm   (enc_imm[gi]),
            .word  (enc_word[gi]),
            .error (enc_err[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         inst_reg    <= '0;
         pending_reg <= '0;
         last_reg    <= 1'b0;
         error_reg   <= 1'b0;
         count_reg   <= '0;
      end else begin
         if (fire) begin
            count_reg <= count_reg + COUNT_WIDTH'(1);
         end
         case (state_reg)
            IDLE, SINGLE, LI_LO: begin
               if (accept) begin
                  inst_reg    <= enc_word[0];
                  pending_reg <= enc_word[1];
                  error_reg   <= enc_err[0] | (li_two & enc_err[1]);
                  if (li_two) begin
                     last_reg  <= 1'b0;
                     state_reg <= LI_HI;
                  end else begin
                     last_reg  <= 1'b1;
                     state_reg <= SINGLE;
                  end
               end else if (fire) begin
                  state_reg <= IDLE;
               end
            end
            LI_HI: begin
               if (fire) begin
                  inst_reg  <= pending_reg;
                  last_reg  <= 1'b1;
                  error_reg <= 1'b0;
                  state_reg <= LI_LO;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign out_inst  = inst_reg;
   assign out_last  = last_reg;
   assign out_error = error_reg;
   assign out_count = count_reg;

endmodule
